gpio_serial_cfg_loader: RTL
===========================

Name: gpio_serial_cfg_loader

Overview:
- Upstream configuration master for the user-project pad array.
- Holds a shadow copy of every pad's configuration word, written from the management side.
- On request, shifts all words serially through the per-pad GPIO control chain, then pulses a load strobe.
- The chain latches the words and drives each pad's DM[2:0], output enable and input-disable controls.

Parameters:
- NUM_PADS, 38: number of pads in the chain.
- CFG_BITS, 13: configuration bits per pad.
- CLK_DIV, 4: wb_clk_i cycles per serial-clock half period; legal range 1..255.
- CFG_DEFAULT, 13'h0403: reset value of every shadow word.

Ports:
- wb_clk_i  input  1  system clock; all logic is on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- cfg_we  input  1  write strobe for a shadow word.
- cfg_addr  input  6  pad index; writes with cfg_addr >= NUM_PADS are ignored.
- cfg_wdata  input  CFG_BITS  shadow write data.
- start  input  1  single-cycle request to transfer all shadow words.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- cfg_err  output  1  one-cycle pulse when a write or start is rejected.
- serial_clock  output  1  chain shift clock.
- serial_data  output  1  chain shift data.
- serial_load  output  1  chain latch strobe.
- serial_resetn  output  1  chain reset, active low.

Behaviour:
- Reset values:
  - All shadow words = CFG_DEFAULT.
  - busy = 0, done = 0, cfg_err = 0.
  - serial_clock = 0, serial_data = 0, serial_load = 0.
  - serial_resetn = 0 during reset; goes to 1 on the first cycle after wb_rst_i deasserts, and stays 1.
- Reset asserted mid-transfer: the transfer aborts immediately. No load pulse and no done pulse are issued.
- Shadow writes:
  - In IDLE, cfg_we with a valid address updates the word on the next edge.
  - In any other state, cfg_we is rejected: shadow is unchanged and cfg_err pulses for 1 cycle.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, FIN.
- IDLE:
  - start=1 moves to SHIFT_LO on the next cycle and asserts busy.
  - The bit counter is loaded with NUM_PADS*CFG_BITS-1.
  - serial_data presents the first bit.
- Bit order:
  - Pad NUM_PADS-1 is sent first, pad 0 last.
  - Within a word, bit CFG_BITS-1 is sent first.
  - After the full shift, pad 0's word sits nearest the chain input.
- SHIFT_LO:
  - serial_clock = 0; serial_data is stable.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - serial_clock = 1 for CLK_DIV cycles.
  - Then, if bits remain: decrement the counter, update serial_data, go to SHIFT_LO.
  - Otherwise go to LOAD.
- serial_data changes only on the cycle serial_clock falls. This gives CLK_DIV cycles of setup and hold.
- LOAD:
  - serial_load = 1 and serial_clock = 0 for CLK_DIV cycles, then go to FIN.
- FIN:
  - Lasts 1 cycle: done = 1, busy = 0, serial_data = 0, then return to IDLE.
- Transfer timing:
  - Total busy time = NUM_PADS*CFG_BITS*2*CLK_DIV + CLK_DIV cycles.
  - Defaults: 494 bits, 3952 shift cycles + 4 load cycles = 3956 busy cycles.
- start while busy: ignored (the transfer in progress continues) and cfg_err pulses.
- start together with cfg_we in IDLE: the write is applied first, so the transfer uses the new value.
- The shift data source is a snapshot of the shadow taken when start is accepted. Rejected writes cannot alter it.
- Counters:
  - Divider counter width is 8 bits.
  - Bit counter width is clog2(NUM_PADS*CFG_BITS).
  - No wrap-around is possible because the state changes when a count reaches 0.

Optional Feature:
- Macro GPIO_CFG_READBACK_EN.
- When defined:
  - Adds input cfg_re (1 bit) and output cfg_rdata (CFG_BITS bits).
  - cfg_re with a valid cfg_addr registers shadow[cfg_addr] onto cfg_rdata on the next cycle. This works in any state.
  - An invalid address returns 0.
  - cfg_rdata resets to 0.
- When undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: after releasing wb_rst_i, serial_resetn=1 on the next cycle; busy=0, serial_load=0. Start with no writes → 494 serial bits, each pad word = 13'h0403 MSB-first.
- Write pad 0 = 13'h1FFF and pad 37 = 13'h0001, then start → the first 13 bits shifted are 0000000000001 and the last 13 are all 1. serial_load is high for 4 cycles; done pulses in cycle 3957 after start; busy is high for exactly 3956 cycles.
- Check every serial_clock rise: serial_data has been stable ≥4 cycles before and ≥4 cycles after.
- During busy, write pad 5 = 13'h0AAA and pulse start → cfg_err pulses twice, shifted data is unchanged, and a later readback of pad 5 shows its old value.
- Assert wb_rst_i at cycle 1000 of a transfer → the next cycle has busy=0, serial_clock=0, serial_load=0, serial_resetn=0; no done pulse follows, and all shadow words are 13'h0403.
- With GPIO_CFG_READBACK_EN and CLK_DIV=1: write pad 12 = 13'h1234, then cfg_re with addr 12 → cfg_rdata = 13'h1234 one cycle later; addr 40 → 0. The transfer takes 988+1 busy cycles.

Source files
------------

// File: rtl/gpio_serial_cfg_loader_if.sv
// Management-side bus for gpio_serial_cfg_loader.
// Readback signals exist only when GPIO_CFG_READBACK_EN is defined.
interface gpio_serial_cfg_loader_if #(
  parameter int CFG_BITS = 13
);
  logic                cfg_we;
  logic [5:0]          cfg_addr;
  logic [CFG_BITS-1:0] cfg_wdata;
  logic                start;
  logic                busy;
  logic                done;
  logic                cfg_err;
`ifdef GPIO_CFG_READBACK_EN
  logic                cfg_re;
  logic [CFG_BITS-1:0] cfg_rdata;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start,
`ifdef GPIO_CFG_READBACK_EN
    output cfg_re,
    input  cfg_rdata,
`endif
    input  busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start,
`ifdef GPIO_CFG_READBACK_EN
    input  cfg_re,
    output cfg_rdata,
`endif
    output busy, done, cfg_err
  );
endinterface

// File: rtl/gpio_serial_cfg_loader.sv
// Shadow config store that shifts every pad word down the GPIO chain.
// Optional shadow readback port: GPIO_CFG_READBACK_EN.
module gpio_serial_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 'h0403
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  gpio_serial_cfg_loader_if.slave bus,
  output logic serial_clock,
  output logic serial_data,
  output logic serial_load,
  output logic serial_resetn
);
  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam int BW    = $clog2(TOTAL);

  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(TOTAL - 1);
  localparam logic [5:0]    ADDR_LAST = 6'(NUM_PADS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SHIFT_LO = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] LOAD     = 3'd3;
  localparam logic [2:0] FIN      = 3'd4;

  logic [2:0]          state;
  logic [7:0]          div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [CFG_BITS-1:0] shadow [NUM_PADS];
  logic [TOTAL-1:0]    image;
  logic [TOTAL-1:0]    snap;
  logic                done_q;
  logic                err_q;
  logic                idle;
  logic                addr_ok;
  logic                wr_ok;
  logic                div_end;

  assign idle    = (state == IDLE);
  assign addr_ok = (bus.cfg_addr <= ADDR_LAST);
  assign wr_ok   = idle & bus.cfg_we & addr_ok;
  assign div_end = (div_cnt == 8'd0);

  assign bus.busy     = (state == SHIFT_LO) ||
                        (state == SHIFT_HI) ||
                        (state == LOAD);
  assign bus.done     = done_q;
  assign bus.cfg_err  = err_q;
  assign serial_clock = (state == SHIFT_HI);
  assign serial_load  = (state == LOAD);
  assign serial_data  = snap[TOTAL-1];

  // Snapshot source: shadow with a same-cycle write already merged in,
  // pad NUM_PADS-1 in the top bits so it leaves first.
  always_comb begin
    image = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      image[i*CFG_BITS +: CFG_BITS] =
        (wr_ok && bus.cfg_addr == 6'(i)) ? bus.cfg_wdata : shadow[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_PADS; i++) shadow[i] <= CFG_DEFAULT;
    end else if (wr_ok) begin
      shadow[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      div_cnt       <= 8'd0;
      bit_cnt       <= '0;
      snap          <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      serial_resetn <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= !idle && (bus.cfg_we || bus.start);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT_LO;
            div_cnt <= DIV_LAST;
            bit_cnt <= BIT_LAST;
            snap    <= image;
          end
        end
        SHIFT_LO: begin
          if (div_end) begin
            state   <= SHIFT_HI;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_end) begin
            div_cnt <= DIV_LAST;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              snap    <= {snap[TOTAL-2:0], 1'b0};
              state   <= SHIFT_LO;
            end else begin
              state <= LOAD;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        LOAD: begin
          if (div_end) begin
            state  <= FIN;
            snap   <= '0;
            done_q <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPIO_CFG_READBACK_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus.cfg_rdata <= '0;
    end else if (bus.cfg_re) begin
      bus.cfg_rdata <= addr_ok ? shadow[bus.cfg_addr] : '0;
    end
  end
`endif
endmodule
